// File: rtl/event_indicator_pkg.sv
// Shared types and sizing helpers for the event_indicator LED blinker.
package event_indicator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Width needed to count 0..N-1 for the longer of the two intervals; at least 1 bit.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Up-counter with clear and a loaded terminal-count compare; serves both blink intervals.
module interval_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  localparam logic [WIDTH-1:0] STEP = WIDTH'(1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count + STEP;
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/event_indicator.sv
// Turns single-cycle events into fixed ON blinks separated by a mandatory OFF gap.
// Queueing of events that arrive mid-blink is enabled by EVENT_INDICATOR_PENDING_EN.
module event_indicator
  import event_indicator_pkg::*;
#(
  parameter int c_ON_CYCLES  = 2500000,
  parameter int c_OFF_CYCLES = 1250000,
  parameter int c_PEND_WIDTH = 4,
  parameter int c_ACTIVE_LOW = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Event,
  output logic                    o_Led,
  output logic                    o_Busy,
  output logic [c_PEND_WIDTH-1:0] o_Pending,
  output logic                    o_Overflow
);

  localparam int            TW       = timer_width(c_ON_CYCLES, c_OFF_CYCLES);
  localparam logic [TW-1:0] ON_LAST  = TW'(c_ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(c_OFF_CYCLES - 1);
  localparam logic          LED_DARK = (c_ACTIVE_LOW != 0);

  state_t        state;
  logic [TW-1:0] limit;
  logic          done;
  logic          clear;
  logic          off_exit;
  logic          go_on;
  logic          lost;

  // Timer is held at zero while idle and restarts on every interval boundary.
  assign limit    = (state == OFF) ? OFF_LAST : ON_LAST;
  assign clear    = (state == IDLE) || done;
  assign off_exit = (state == OFF) && done;

  interval_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .clear(clear),
    .limit(limit),
    .done (done)
  );

`ifdef EVENT_INDICATOR_PENDING_EN
  localparam logic [c_PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [c_PEND_WIDTH-1:0] PEND_ONE = c_PEND_WIDTH'(1);

  logic [c_PEND_WIDTH-1:0] pending;
  logic                    queue_event;

  // At the OFF exit the strobe is either consumed or cancels the decrement.
  assign queue_event = i_Event && ((state == ON) || ((state == OFF) && !off_exit));
  assign lost        = queue_event && (pending == PEND_MAX);
  assign go_on       = (pending != '0) || i_Event;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      pending <= '0;
    end else if (off_exit && (pending != '0) && !i_Event) begin
      pending <= pending - PEND_ONE;
    end else if (queue_event && !lost) begin
      pending <= pending + PEND_ONE;
    end
  end

  assign o_Pending = pending;
`else
  assign lost      = i_Event && ((state == ON) || ((state == OFF) && !off_exit));
  assign go_on     = i_Event;
  assign o_Pending = '0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      o_Led      <= LED_DARK;
      o_Busy     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (lost) begin
        o_Overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_Event) begin
            state  <= ON;
            o_Led  <= ~LED_DARK;
            o_Busy <= 1'b1;
          end
        end
        ON: begin
          if (done) begin
            state <= OFF;
            o_Led <= LED_DARK;
          end
        end
        OFF: begin
          if (done) begin
            if (go_on) begin
              state <= ON;
              o_Led <= ~LED_DARK;
            end else begin
              state  <= IDLE;
              o_Busy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          o_Led  <= LED_DARK;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_indicator.sv
// Checks two event_indicator instances (LED active-high and active-low) against a blink-schedule model.
// Builds with or without EVENT_INDICATOR_PENDING_EN; the model follows the same macro.
module tb_event_indicator;

  localparam int ON_CYC  = 4;
  localparam int OFF_CYC = 3;
  localparam int PW      = 2;
  localparam int PMAX    = 3;
`ifdef EVENT_INDICATOR_PENDING_EN
  localparam bit QUEUEING = 1'b1;
`else
  localparam bit QUEUEING = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev  = 1'b0;
  logic          led_hi, busy_hi, ovf_hi;
  logic          led_lo, busy_lo, ovf_lo;
  logic [PW-1:0] pend_hi, pend_lo;

  int tests    = 0;
  int failures = 0;

  // Model: phase 0 idle / 1 lit / 2 dark, cycles left in phase, queued count, lost flag.
  int m_phase = 0;
  int m_left  = 0;
  int m_queue = 0;
  bit m_lost  = 1'b0;

  always #5 clk = ~clk;

  event_indicator #(
    .c_ON_CYCLES (ON_CYC),
    .c_OFF_CYCLES(OFF_CYC),
    .c_PEND_WIDTH(PW),
    .c_ACTIVE_LOW(0)
  ) dut_hi (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Event   (ev),
    .o_Led     (led_hi),
    .o_Busy    (busy_hi),
    .o_Pending (pend_hi),
    .o_Overflow(ovf_hi)
  );

  event_indicator #(
    .c_ON_CYCLES (ON_CYC),
    .c_OFF_CYCLES(OFF_CYC),
    .c_PEND_WIDTH(PW),
    .c_ACTIVE_LOW(1)
  ) dut_lo (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Event   (ev),
    .o_Led     (led_lo),
    .o_Busy    (busy_lo),
    .o_Pending (pend_lo),
    .o_Overflow(ovf_lo)
  );

  task automatic enqueue();
    if (!QUEUEING || m_queue == PMAX) m_lost = 1'b1;
    else m_queue++;
  endtask

  // One clock edge of the blink schedule.
  task automatic modelStep(input bit e, input bit r);
    bit last;
    if (r) begin
      m_phase = 0; m_left = 0; m_queue = 0; m_lost = 1'b0;
      return;
    end
    last = (m_left == 1);
    case (m_phase)
      0: if (e) begin m_phase = 1; m_left = ON_CYC; end
      1: begin
        if (e) enqueue();
        if (last) begin m_phase = 2; m_left = OFF_CYC; end
        else m_left--;
      end
      default: begin
        if (!last) begin
          if (e) enqueue();
          m_left--;
        end else if (m_queue > 0 || e) begin
          if (m_queue > 0 && !e) m_queue--;
          m_phase = 1; m_left = ON_CYC;
        end else begin
          m_phase = 0; m_left = 0;
        end
      end
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit r);
    ev  = e;
    rst = r;
    @(posedge clk);
    modelStep(e, r);
    #1;
    checkOutput("led_hi", 32'(led_hi), 32'(m_phase == 1));
    checkOutput("led_lo", 32'(led_lo), 32'(m_phase != 1));
    checkOutput("busy_hi", 32'(busy_hi), 32'(m_phase != 0));
    checkOutput("busy_lo", 32'(busy_lo), 32'(m_phase != 0));
    checkOutput("pend_hi", 32'(pend_hi), 32'(m_queue));
    checkOutput("pend_lo", 32'(pend_lo), 32'(m_queue));
    checkOutput("ovf_hi", 32'(ovf_hi), 32'(m_lost));
    checkOutput("ovf_lo", 32'(ovf_lo), 32'(m_lost));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int mode;
    bit e;
    bit r;

    // Reset, including an event in the same cycle as reset.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("reset_led_lo", 32'(led_lo), 32'd1);
    checkOutput("reset_busy", 32'(busy_hi), 32'd0);

    // Single pulse: 4 lit, 3 dark and busy, then idle.
    applyStimulus(1'b1, 1'b0);
    checkOutput("pulse_latency", 32'(led_hi), 32'd1);
    checkOutput("pulse_lo_dark", 32'(led_lo), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("pulse_on", 32'(led_hi), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("pulse_off_led", 32'(led_hi), 32'd0);
      checkOutput("pulse_off_busy", 32'(busy_hi), 32'd1);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("pulse_idle_busy", 32'(busy_hi), 32'd0);
    checkOutput("pulse_idle_pend", 32'(pend_hi), 32'd0);

    // Three consecutive pulses.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("burst3_pend", 32'(pend_hi), QUEUEING ? 32'd2 : 32'd0);
    checkOutput("burst3_ovf", 32'(ovf_hi), QUEUEING ? 32'd0 : 32'd1);
    idle(25);

    // Six pulses: queue saturates and overflow sticks.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("sat_ovf", 32'(ovf_hi), 32'd1);
    checkOutput("sat_pend", 32'(pend_hi), QUEUEING ? 32'd3 : 32'd0);
    idle(35);
    checkOutput("sat_ovf_sticky", 32'(ovf_hi), 32'd1);

    // Event on the last dark cycle, first with an empty queue, then with one queued.
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    idle(6);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lastoff_q0_led", 32'(led_hi), 32'd1);
    checkOutput("lastoff_q0_pend", 32'(pend_hi), 32'd0);
    applyStimulus(1'b1, 1'b0);
    idle(5);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lastoff_q1_led", 32'(led_hi), 32'd1);
    checkOutput("lastoff_q1_pend", 32'(pend_hi), QUEUEING ? 32'd1 : 32'd0);
    idle(20);

    // Reset in the middle of a blink with two queued.
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_led", 32'(led_hi), 32'd0);
    checkOutput("midrst_pend", 32'(pend_hi), 32'd0);
    checkOutput("midrst_busy", 32'(busy_hi), 32'd0);
    checkOutput("midrst_ovf", 32'(ovf_hi), 32'd0);
    idle(3);

    // Random traffic with varying event density and occasional resets.
    mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 3);
      case (mode)
        0:       e = ($urandom_range(0, 19) == 0);
        1:       e = ($urandom_range(0, 3) == 0);
        2:       e = ($urandom_range(0, 1) == 0);
        default: e = 1'b0;
      endcase
      r = ($urandom_range(0, 249) == 0);
      applyStimulus(e, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
